// File: rtl/dmem_param.sv
// Parametrised RISC-V data memory: byte-lane banks, registered loads with extension,
// fault detection, post-reset clear sequencer, and a read-first debug port.

module dmem_lane #(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] ridx,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [7:0]       rdata,
  output logic [7:0]       dbg_rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;

  // Both read ports are read-first against a same-edge write.
  always_ff @(posedge clk)
    if (rst) begin
      rdata     <= '0;
      dbg_rdata <= '0;
    end else begin
      rdata     <= mem[ridx];
      dbg_rdata <= mem[dbg_idx];
    end
endmodule

module dmem_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W/8)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_size,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_fault,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_rdata
);
  localparam int BYTES  = DATA_W/8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STAGES = 1;

  typedef enum logic {CLEAR, RUN} state_t;
  typedef struct packed {
    logic             load;
    logic             fault;
    logic [2:0]       size;
    logic [OFF_W-1:0] off;
  } rsp_ctl_t;

  state_t     state, state_nx;
  logic [IDX_W-1:0] clr_ptr, clr_nx;
  logic [STAGES:0]  vld_pipe;
  rsp_ctl_t   ctl_d, ctl_q;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             legal, misal, fault, accept, clearing;
  logic [BYTES-1:0] lane_mask, lane_we;
  logic [DATA_W-1:0] wshift;
  logic [BYTES-1:0][7:0] lane_wdata, lane_rdata, lane_dbg;
  logic [DATA_W-1:0] rword, shifted, ext;

  always_ff @(posedge clk)
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_nx;
    end

  always_comb begin
    state_nx = state;
    clr_nx   = clr_ptr;
    if (state == CLEAR) begin
      clr_nx = clr_ptr + 1'b1;
      if (clr_ptr == IDX_W'(DEPTH-1)) state_nx = RUN;
    end
  end

  assign init_busy = (state == CLEAR);
  assign clearing  = (state == CLEAR) && !rst;
  assign accept    = req_valid && (state == RUN) && !rst;

  assign idx = req_addr[ADDR_W-1:OFF_W];
  assign off = req_addr[OFF_W-1:0];

  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (req_size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      3'b011, 3'b110:                         legal = (DATA_W == 64);
      default:                                legal = 1'b0;
    endcase
    case (req_size)
      3'b001, 3'b101: misal = req_addr[0];
      3'b010, 3'b110: misal = |req_addr[1:0];
      3'b011:         misal = |req_addr[2:0];
      default:        misal = 1'b0;
    endcase
  end
  assign fault = !legal || misal;

  // Lanes covered by the access: [off, off + 2^size[1:0]).
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++)
      lane_mask[i] = (i >= int'(off)) && ((i - int'(off)) < (1 << req_size[1:0]));
  end

  assign wshift = req_wdata << {off, 3'b000};

  always_comb begin
    lane_we    = '0;
    lane_wdata = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_we[i]    = clearing || (accept && req_we && !fault && lane_mask[i]);
      lane_wdata[i] = clearing ? 8'h00 : wshift[8*i +: 8];
    end
  end

  genvar g;
  generate
    for (g = 0; g < BYTES; g++) begin : g_lane
      dmem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .we        (lane_we[g]),
        .widx      (clearing ? clr_ptr : idx),
        .wdata     (lane_wdata[g]),
        .ridx      (idx),
        .dbg_idx   (dbg_addr),
        .rdata     (lane_rdata[g]),
        .dbg_rdata (lane_dbg[g])
      );
    end
  endgenerate

  assign dbg_rdata = lane_dbg;

  assign vld_pipe[0] = accept;
  assign ctl_d = '{load: !req_we, fault: fault, size: req_size, off: off};

  always_ff @(posedge clk)
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      ctl_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      ctl_q              <= ctl_d;
    end

  assign rword   = lane_rdata;
  assign shifted = rword >> {ctl_q.off, 3'b000};

  always_comb begin
    case (ctl_q.size)
      3'b000:  ext = DATA_W'($signed(shifted[7:0]));
      3'b001:  ext = DATA_W'($signed(shifted[15:0]));
      3'b010:  ext = DATA_W'($signed(shifted[31:0]));
      3'b100:  ext = DATA_W'(shifted[7:0]);
      3'b101:  ext = DATA_W'(shifted[15:0]);
      3'b110:  ext = DATA_W'(shifted[31:0]);
      default: ext = shifted;
    endcase
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_fault = vld_pipe[STAGES] && ctl_q.fault;
  assign rsp_rdata = (vld_pipe[STAGES] && ctl_q.load && !ctl_q.fault) ? ext : '0;
endmodule

// File: tb/tb_dmem_param.sv
// Directed bench for dmem_param: 32-bit/512-word instance plus a small 64-bit instance.

module tb_dmem_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // 32-bit, 512 words
  logic        rst, init_busy, req_valid, req_we, rsp_valid, rsp_fault;
  logic [2:0]  req_size;
  logic [10:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata, dbg_rdata;
  logic [8:0]  dbg_addr;

  // 64-bit, 16 words
  logic        rst64, init_busy64, req_valid64, req_we64, rsp_valid64, rsp_fault64;
  logic [2:0]  req_size64;
  logic [6:0]  req_addr64;
  logic [63:0] req_wdata64, rsp_rdata64, dbg_rdata64;
  logic [3:0]  dbg_addr64;

  dmem_param #(.DATA_W(32), .DEPTH(512)) dut32 (
    .clk(clk), .rst(rst), .init_busy(init_busy), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  dmem_param #(.DATA_W(64), .DEPTH(16)) dut64 (
    .clk(clk), .rst(rst64), .init_busy(init_busy64), .req_valid(req_valid64), .req_we(req_we64),
    .req_size(req_size64), .req_addr(req_addr64), .req_wdata(req_wdata64), .rsp_valid(rsp_valid64),
    .rsp_rdata(rsp_rdata64), .rsp_fault(rsp_fault64), .dbg_addr(dbg_addr64), .dbg_rdata(dbg_rdata64)
  );

  // One request on the 32-bit port; returns the response seen one edge later.
  task automatic req32(input logic we, input logic [2:0] sz, input logic [10:0] a,
                       input logic [31:0] wd, output logic v, output logic [31:0] rd, output logic f);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    v = rsp_valid; rd = rsp_rdata; f = rsp_fault;
  endtask

  task automatic req64(input logic we, input logic [2:0] sz, input logic [6:0] a,
                       input logic [63:0] wd, output logic v, output logic [63:0] rd, output logic f);
    req_valid64 = 1'b1; req_we64 = we; req_size64 = sz; req_addr64 = a; req_wdata64 = wd;
    @(posedge clk); #1;
    req_valid64 = 1'b0; req_we64 = 1'b0;
    v = rsp_valid64; rd = rsp_rdata64; f = rsp_fault64;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (init_busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0 || dbg_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_state busy=%b v=%b rd=%h f=%b dbg=%h, expected 1 0 0 0 0",
               init_busy, rsp_valid, rsp_rdata, rsp_fault, dbg_rdata);
    end
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    nvec++;
    if (n !== 512) begin nerr++; $display("FAIL clear_len got %0d cycles, expected 512", n); end
    dbg_addr = 9'd5;
    @(posedge clk); #1;
    nvec++;
    if (dbg_rdata !== 32'h0) begin nerr++; $display("FAIL dbg_clear5 got %h expected 0", dbg_rdata); end
    dbg_addr = 9'd511;
    @(posedge clk); #1;
    nvec++;
    if (dbg_rdata !== 32'h0) begin nerr++; $display("FAIL dbg_clear511 got %h expected 0", dbg_rdata); end
    nvec++;
    if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL idle_valid got %b expected 0", rsp_valid); end
  endtask

  task automatic test_load_ext;
    logic v, f; logic [31:0] rd;
    req32(1'b1, 3'b010, 11'h10, 32'hDEADBEEF, v, rd, f);
    nvec++;
    if (v !== 1'b1 || rd !== 32'h0 || f !== 1'b0) begin
      nerr++; $display("FAIL sw_rsp v=%b rd=%h f=%b expected 1 0 0", v, rd, f);
    end
    req32(1'b0, 3'b000, 11'h13, 32'h0, v, rd, f);
    nvec++;
    if (v !== 1'b1 || rd !== 32'hFFFFFFDE) begin nerr++; $display("FAIL lb_13 got %h expected ffffffde", rd); end
    req32(1'b0, 3'b100, 11'h13, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'h000000DE) begin nerr++; $display("FAIL lbu_13 got %h expected 000000de", rd); end
    req32(1'b0, 3'b001, 11'h10, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'hFFFFBEEF) begin nerr++; $display("FAIL lh_10 got %h expected ffffbeef", rd); end
    req32(1'b0, 3'b101, 11'h12, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'h0000DEAD) begin nerr++; $display("FAIL lhu_12 got %h expected 0000dead", rd); end
    req32(1'b0, 3'b000, 11'h11, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'hFFFFFFBE) begin nerr++; $display("FAIL lb_11 got %h expected ffffffbe", rd); end
  endtask

  task automatic test_byte_store;
    logic v, f; logic [31:0] rd;
    req32(1'b1, 3'b010, 11'h20, 32'h11223344, v, rd, f);
    req32(1'b1, 3'b000, 11'h21, 32'hFFFFFF5A, v, rd, f);
    req32(1'b0, 3'b010, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (v !== 1'b1 || rd !== 32'h11225A44) begin nerr++; $display("FAIL sb_lanes got %h expected 11225a44", rd); end
  endtask

  task automatic test_faults;
    logic v, f; logic [31:0] rd;
    req32(1'b1, 3'b001, 11'h22, 32'h0000ABCD, v, rd, f);
    req32(1'b0, 3'b010, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'hABCD5A44) begin nerr++; $display("FAIL sh_22 got %h expected abcd5a44", rd); end
    req32(1'b1, 3'b001, 11'h23, 32'h00001111, v, rd, f);
    nvec++;
    if (v !== 1'b1 || f !== 1'b1 || rd !== 32'h0) begin
      nerr++; $display("FAIL sh_misal v=%b f=%b rd=%h expected 1 1 0", v, f, rd);
    end
    req32(1'b0, 3'b010, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'hABCD5A44 || f !== 1'b0) begin nerr++; $display("FAIL sh_misal_nowrite got %h f=%b expected abcd5a44 0", rd, f); end
    req32(1'b0, 3'b111, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (f !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL size111 f=%b rd=%h expected 1 0", f, rd); end
    req32(1'b0, 3'b011, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (f !== 1'b1) begin nerr++; $display("FAIL ld_on32 f=%b expected 1", f); end
    req32(1'b0, 3'b010, 11'h22, 32'h0, v, rd, f);
    nvec++;
    if (f !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL lw_misal f=%b rd=%h expected 1 0", f, rd); end
    req32(1'b1, 3'b110, 11'h20, 32'h0, v, rd, f);
    req32(1'b0, 3'b010, 11'h20, 32'h0, v, rd, f);
    nvec++;
    if (rd !== 32'hABCD5A44) begin nerr++; $display("FAIL swu_on32_nowrite got %h expected abcd5a44", rd); end
  endtask

  task automatic test_dbg_read_first;
    logic v, f; logic [31:0] rd;
    dbg_addr = 9'd12;
    req32(1'b1, 3'b010, 11'h30, 32'hCAFEF00D, v, rd, f);
    nvec++;
    if (dbg_rdata !== 32'h0) begin nerr++; $display("FAIL dbg_old got %h expected 0", dbg_rdata); end
    @(posedge clk); #1;
    nvec++;
    if (dbg_rdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL dbg_new got %h expected cafef00d", dbg_rdata); end
  endtask

  task automatic test_reset_mid_clear;
    logic v, f; logic [31:0] rd; int n;
    req32(1'b1, 3'b010, 11'h40, 32'h12345678, v, rd, f);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    req32(1'b1, 3'b010, 11'h40, 32'hFFFFFFFF, v, rd, f);
    nvec++;
    if (v !== 1'b0) begin nerr++; $display("FAIL clear_req_valid got %b expected 0", v); end
    n = 301;
    while (init_busy === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    nvec++;
    if (n !== 512) begin nerr++; $display("FAIL reclear_len got %0d cycles, expected 512", n); end
    req32(1'b0, 3'b010, 11'h40, 32'h0, v, rd, f);
    nvec++;
    if (v !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL clear_req_nowrite v=%b rd=%h expected 1 0", v, rd); end
  endtask

  task automatic test_dw64;
    logic v, f; logic [63:0] rd; int n;
    rst64 = 1'b1; @(posedge clk); #1; rst64 = 1'b0;
    n = 0;
    while (init_busy64 === 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    nvec++;
    if (n !== 16) begin nerr++; $display("FAIL clear64_len got %0d expected 16", n); end
    req64(1'b1, 3'b011, 7'h08, 64'h8000000012345678, v, rd, f);
    req64(1'b0, 3'b110, 7'h0C, 64'h0, v, rd, f);
    nvec++;
    if (v !== 1'b1 || rd !== 64'h0000000080000000) begin nerr++; $display("FAIL lwu64 got %h expected 0000000080000000", rd); end
    req64(1'b0, 3'b010, 7'h0C, 64'h0, v, rd, f);
    nvec++;
    if (rd !== 64'hFFFFFFFF80000000) begin nerr++; $display("FAIL lw64 got %h expected ffffffff80000000", rd); end
    req64(1'b0, 3'b011, 7'h08, 64'h0, v, rd, f);
    nvec++;
    if (rd !== 64'h8000000012345678) begin nerr++; $display("FAIL ld64 got %h expected 8000000012345678", rd); end
    req64(1'b0, 3'b000, 7'h0F, 64'h0, v, rd, f);
    nvec++;
    if (rd !== 64'hFFFFFFFFFFFFFF80) begin nerr++; $display("FAIL lb64 got %h expected ffffffffffffff80", rd); end
    req64(1'b0, 3'b101, 7'h0A, 64'h0, v, rd, f);
    nvec++;
    if (rd !== 64'h0000000000001234) begin nerr++; $display("FAIL lhu64 got %h expected 1234", rd); end
    req64(1'b0, 3'b011, 7'h0C, 64'h0, v, rd, f);
    nvec++;
    if (f !== 1'b1 || rd !== 64'h0) begin nerr++; $display("FAIL ld64_misal f=%b rd=%h expected 1 0", f, rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000; req_addr = '0;
    req_wdata = '0; dbg_addr = '0;
    rst64 = 1'b1; req_valid64 = 1'b0; req_we64 = 1'b0; req_size64 = 3'b000; req_addr64 = '0;
    req_wdata64 = '0; dbg_addr64 = '0;
    test_reset;
    test_load_ext;
    test_byte_store;
    test_faults;
    test_dbg_read_first;
    test_reset_mid_clear;
    test_dw64;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
